// File: rtl/srt4_iteration.sv
// srt4_iteration: radix-4 SRT digit-recurrence core of an unsigned divider.
// Runs the digit loop, on-the-fly quotient conversion and final correction.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start            request, sampled only in IDLE
//   divisor_star     normalized divisor (B << n)
//   dividend_star    aligned dividend (A<<1 for even n, A for odd n)
//   iterations       radix-4 digit count, 0 flags divide-by-zero
//   recovery         DW-n, used to de-normalize the remainder
//   busy             high while iterating or correcting
//   done             one-cycle pulse, results valid
//   quotient         floor(A/B)
//   remainder        A mod B
//   div_zero         divide-by-zero flag, valid with done
module srt4_iteration #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW+2:0]   divisor_star,
  input  logic [DW+5:0]   dividend_star,
  input  logic [DW/2-1:0] iterations,
  input  logic [DW/2-1:0] recovery,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero
);

  localparam int WW = DW + 6;
  localparam int QW = DW + 2;
  localparam int CW = DW / 2;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    CORRECT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [WW-1:0] w_q, w_d;
  logic [DW+2:0]        d_q, d_d;
  logic [CW-1:0]        rec_q, rec_d;
  logic [CW-1:0]        it_q, it_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [QW-1:0]        qa_q, qa_d;
  logic [QW-1:0]        qm_q, qm_d;
  logic [DW-1:0]        quo_q, quo_d;
  logic [DW-1:0]        rem_q, rem_d;
  logic                 dz_q, dz_d;

  // The divisor is used three bits above its stored weight, so that
  // 4^iterations * dividend / D equals A/B exactly.
  logic signed [WW-1:0] dv;
  logic signed [WW-1:0] dh;
  logic signed [WW-1:0] d3h;
  logic signed [WW-1:0] w4;

  assign dv  = $signed({d_q, 3'b000});
  assign dh  = dv >>> 1;
  assign d3h = dv + dh;
  assign w4  = w_q <<< 2;

  logic ge3h, ge1h, gm1h, gm3h;

  assign ge3h = (w4 >= d3h);
  assign ge1h = (w4 >= dh);
  assign gm1h = (w4 >= -dh);
  assign gm3h = (w4 >= -d3h);

  logic signed [WW-1:0] w_nx;
  logic [QW-1:0]        qa_nx;
  logic [QW-1:0]        qm_nx;

  // Digit selection plus on-the-fly update of Q and QM = Q-1.
  always_comb begin
    w_nx  = w4;
    qa_nx = {qa_q[QW-3:0], 2'b00};
    qm_nx = {qm_q[QW-3:0], 2'b11};
    unique case (1'b1)
      ge3h: begin
        w_nx  = w4 - (dv <<< 1);
        qa_nx = {qa_q[QW-3:0], 2'b10};
        qm_nx = {qa_q[QW-3:0], 2'b01};
      end
      ge1h & ~ge3h: begin
        w_nx  = w4 - dv;
        qa_nx = {qa_q[QW-3:0], 2'b01};
        qm_nx = {qa_q[QW-3:0], 2'b00};
      end
      gm1h & ~ge1h: begin
        w_nx  = w4;
        qa_nx = {qa_q[QW-3:0], 2'b00};
        qm_nx = {qm_q[QW-3:0], 2'b11};
      end
      gm3h & ~gm1h: begin
        w_nx  = w4 + dv;
        qa_nx = {qm_q[QW-3:0], 2'b11};
        qm_nx = {qm_q[QW-3:0], 2'b10};
      end
      ~gm3h: begin
        w_nx  = w4 + (dv <<< 1);
        qa_nx = {qm_q[QW-3:0], 2'b10};
        qm_nx = {qm_q[QW-3:0], 2'b01};
      end
      default: ;
    endcase
  end

  logic                 w_neg;
  logic [WW-1:0]        w_fix;
  logic [CW-1:0]        sh;

  assign w_neg = w_q[WW-1];
  assign w_fix = w_neg ? w_q + dv : w_q;
  // Binary point sits 3 bits up, plus n = DW - recovery.
  assign sh    = CW'(DW + 3) - rec_q;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    d_d     = d_q;
    rec_d   = rec_q;
    it_d    = it_q;
    cnt_d   = cnt_q;
    qa_d    = qa_q;
    qm_d    = qm_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          d_d   = divisor_star;
          rec_d = recovery;
          it_d  = iterations;
          cnt_d = iterations;
          w_d   = $signed(dividend_star);
          qa_d  = '0;
          qm_d  = '0;
          // A zero-digit request still spends one cycle in
          // CORRECT so latency stays iterations+2.
          state_d = (iterations == '0) ? CORRECT : ITER;
        end
      end
      ITER: begin
        w_d   = w_nx;
        qa_d  = qa_nx;
        qm_d  = qm_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = CORRECT;
        end
      end
      CORRECT: begin
        state_d = DONE;
        if (it_q == '0) begin
          quo_d = '1;
          rem_d = '0;
          dz_d  = 1'b1;
        end else begin
          quo_d = DW'(w_neg ? qa_q - QW'(1) : qa_q);
          rem_d = DW'(w_fix >> sh);
          dz_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      d_q     <= '0;
      rec_q   <= '0;
      it_q    <= '0;
      cnt_q   <= '0;
      qa_q    <= '0;
      qm_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      d_q     <= d_d;
      rec_q   <= rec_d;
      it_q    <= it_d;
      cnt_q   <= cnt_d;
      qa_q    <= qa_d;
      qm_q    <= qm_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = (state_q == ITER) || (state_q == CORRECT);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule
